// File: rtl/analog_avg_filter_pkg.sv
// Width helpers shared by the analog_avg_filter slice.
// Sample RAM address layout is {channel, window pointer}, with the channel in the upper bits.
package analog_filter_pkg;

  function automatic int clog2(input int unsigned value);
    int unsigned rem;
    int result;
    rem = (value > 0) ? value - 1 : 0;
    result = 0;
    while (rem != 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  // A single-channel build still carries a 1-bit channel tag.
  function automatic int chWidth(input int unsigned channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  function automatic int sumWidth(input int dw, input int log2Depth);
    return dw + log2Depth;
  endfunction

  function automatic int ramAddrWidth(input int unsigned channels, input int log2Depth);
    return chWidth(channels) + log2Depth;
  endfunction

endpackage

// File: rtl/analog_avg_filter_sample_ram.sv
// Simple dual-port window storage for all channels, with a registered read port.
// It has no reset. Entries that were never written are masked by the fill counts.
module filter_sample_ram #(
  parameter int DW      = 12,
  parameter int ENTRIES = 32,
  parameter int AW      = 5
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  logic [DW-1:0] mem [ENTRIES];
  logic [DW-1:0] rdData_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rdData_q <= mem[rd_addr_i];
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/analog_avg_filter.sv
// Time-multiplexed, per-channel moving-average filter with a fixed 2-cycle latency.
// Define ANALOG_FILTER_PRIME_EN to prime each channel's window with its first sample.
module analog_avg_filter
  import analog_filter_pkg::*;
#(
  parameter int DW         = 12,
  parameter int CHANNELS   = 4,
  parameter int LOG2_DEPTH = 3,
  localparam int CHW       = chWidth(CHANNELS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  in_data,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  out_data
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = sumWidth(DW, LOG2_DEPTH);
  localparam int AW    = ramAddrWidth(CHANNELS, LOG2_DEPTH);
  localparam int FW    = LOG2_DEPTH + 1;
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

  logic [SW-1:0]         sum_q   [CHANNELS];
  logic [SW-1:0]         sum_d   [CHANNELS];
  logic [LOG2_DEPTH-1:0] wrPtr_q [CHANNELS];
  logic [LOG2_DEPTH-1:0] wrPtr_d [CHANNELS];
  logic [FW-1:0]         fill_q  [CHANNELS];
  logic [FW-1:0]         fill_d  [CHANNELS];

  logic                  s1Valid_q, s1Valid_d;
  logic [CHW-1:0]        s1Ch_q, s1Ch_d;
  logic [LOG2_DEPTH-1:0] s1Ptr_q, s1Ptr_d;
  logic [DW-1:0]         s1Data_q, s1Data_d;
  logic                  s1Full_q, s1Full_d;

  logic                  outValid_q, outValid_d;
  logic [CHW-1:0]        outCh_q, outCh_d;
  logic [DW-1:0]         outData_q, outData_d;

`ifdef ANALOG_FILTER_PRIME_EN
  logic [DW-1:0]         prime_q [CHANNELS];
  logic [DW-1:0]         prime_d [CHANNELS];
  logic                  s1First_q, s1First_d;
`endif

  logic                  chOk;
  logic                  accept;
  logic [CHW-1:0]        chSel;
  logic [SW-1:0]         oldEff;
  logic [SW-1:0]         newSum;
  logic                  ramRdEn;
  logic                  ramWrEn;
  logic [AW-1:0]         ramRdAddr;
  logic [AW-1:0]         ramWrAddr;
  logic [DW-1:0]         ramRdData;

  // S1 issues the RAM read of the slot that is about to be overwritten.
  // The channel is clamped so that out-of-range tags never index the flop arrays.
  always_comb begin
    chOk      = 32'(in_ch) < CHANNELS;
    accept    = in_valid && !clear && chOk;
    chSel     = chOk ? in_ch : '0;
    s1Valid_d = accept;
    s1Ch_d    = chSel;
    s1Ptr_d   = wrPtr_q[chSel];
    s1Data_d  = in_data;
    s1Full_d  = (fill_q[chSel] == FILL_FULL);
    ramRdEn   = accept;
    ramRdAddr = {chSel, wrPtr_q[chSel]};
`ifdef ANALOG_FILTER_PRIME_EN
    s1First_d = (fill_q[chSel] == '0);
`endif
  end

  // S2 reads sum_q after the previous S2 edge has written it, so back-to-back
  // samples on one channel already see the updated sum.
  always_comb begin
`ifdef ANALOG_FILTER_PRIME_EN
    oldEff = s1Full_q ? SW'(ramRdData) : SW'(prime_q[s1Ch_q]);
    newSum = s1First_q ? (SW'(s1Data_q) << LOG2_DEPTH)
                       : (sum_q[s1Ch_q] + SW'(s1Data_q) - oldEff);
`else
    oldEff = s1Full_q ? SW'(ramRdData) : '0;
    newSum = sum_q[s1Ch_q] + SW'(s1Data_q) - oldEff;
`endif
    ramWrEn    = s1Valid_q && !clear;
    ramWrAddr  = {s1Ch_q, s1Ptr_q};
    outValid_d = ramWrEn;
    outCh_d    = outValid_d ? s1Ch_q : outCh_q;
    outData_d  = outValid_d ? newSum[SW-1:LOG2_DEPTH] : outData_q;
  end

  always_comb begin
    sum_d   = sum_q;
    wrPtr_d = wrPtr_q;
    fill_d  = fill_q;
`ifdef ANALOG_FILTER_PRIME_EN
    prime_d = prime_q;
`endif
    if (clear) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sum_d[i]   = '0;
        wrPtr_d[i] = '0;
        fill_d[i]  = '0;
      end
    end else begin
      if (accept) begin
        wrPtr_d[chSel] = wrPtr_q[chSel] + 1'b1;
        if (fill_q[chSel] != FILL_FULL) fill_d[chSel] = fill_q[chSel] + 1'b1;
`ifdef ANALOG_FILTER_PRIME_EN
        if (fill_q[chSel] == '0) prime_d[chSel] = in_data;
`endif
      end
      if (s1Valid_q) sum_d[s1Ch_q] = newSum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sum_q[i]   <= '0;
        wrPtr_q[i] <= '0;
        fill_q[i]  <= '0;
`ifdef ANALOG_FILTER_PRIME_EN
        prime_q[i] <= '0;
`endif
      end
      s1Valid_q  <= 1'b0;
      s1Ch_q     <= '0;
      s1Ptr_q    <= '0;
      s1Data_q   <= '0;
      s1Full_q   <= 1'b0;
`ifdef ANALOG_FILTER_PRIME_EN
      s1First_q  <= 1'b0;
`endif
      outValid_q <= 1'b0;
      outCh_q    <= '0;
      outData_q  <= '0;
    end else begin
      sum_q      <= sum_d;
      wrPtr_q    <= wrPtr_d;
      fill_q     <= fill_d;
`ifdef ANALOG_FILTER_PRIME_EN
      prime_q    <= prime_d;
      s1First_q  <= s1First_d;
`endif
      s1Valid_q  <= s1Valid_d;
      s1Ch_q     <= s1Ch_d;
      s1Ptr_q    <= s1Ptr_d;
      s1Data_q   <= s1Data_d;
      s1Full_q   <= s1Full_d;
      outValid_q <= outValid_d;
      outCh_q    <= outCh_d;
      outData_q  <= outData_d;
    end
  end

  filter_sample_ram #(
    .DW      (DW),
    .ENTRIES (CHANNELS * DEPTH),
    .AW      (AW)
  ) u_sampleRam (
    .clk_i     (clk),
    .rd_en_i   (ramRdEn),
    .rd_addr_i (ramRdAddr),
    .rd_data_o (ramRdData),
    .wr_en_i   (ramWrEn),
    .wr_addr_i (ramWrAddr),
    .wr_data_i (s1Data_q)
  );

  assign out_valid = outValid_q;
  assign out_ch    = outCh_q;
  assign out_data  = outData_q;

endmodule

// File: tb/tb_analog_avg_filter.sv
// Testbench for analog_avg_filter: a queue-based window model, table-driven ramps, and randomized traffic.
// CHANNELS=5 gives a 3-bit channel tag, so that tags 5..7 can be driven as invalid channels.
module tb_analog_avg_filter;

  localparam int DW         = 12;
  localparam int CHANNELS   = 5;
  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 8;
  localparam int CHW        = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic           in_valid;
  logic [CHW-1:0] in_ch;
  logic [DW-1:0]  in_data;
  logic           out_valid;
  logic [CHW-1:0] out_ch;
  logic [DW-1:0]  out_data;

  analog_avg_filter #(
    .DW         (DW),
    .CHANNELS   (CHANNELS),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {int due; int ch; int data;} expect_t;
  typedef struct {int ch; int data;} obs_t;
  typedef struct {int ch; int data; int expData;} vec_t;

  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  expect_t expQ[$];
  obs_t    observed[$];
  int      window[CHANNELS][$];
  vec_t    rampVecs[10];
  vec_t    stepVecs[16];

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, actual, required);
    end
  endtask

  // The window is modelled as a list of the most recent DEPTH samples; missing entries count as zero.
  task automatic modelPush(input int ch, input int data, output int avg);
    int sum;
`ifdef ANALOG_FILTER_PRIME_EN
    if (window[ch].size() == 0) begin
      repeat (DEPTH) window[ch].push_back(data);
    end else begin
      window[ch].push_back(data);
      void'(window[ch].pop_front());
    end
`else
    window[ch].push_back(data);
    if (window[ch].size() > DEPTH) void'(window[ch].pop_front());
`endif
    sum = 0;
    foreach (window[ch][i]) sum += window[ch][i];
    avg = sum / DEPTH;
  endtask

  task automatic modelReset();
    for (int c = 0; c < CHANNELS; c++) window[c].delete();
  endtask

  task automatic applyStimulus(input bit v, input int ch, input int data, input bit clr);
    int avg;
    expect_t keep[$];
    in_valid = v;
    in_ch    = CHW'(ch);
    in_data  = DW'(data);
    clear    = clr;
    if (clr) begin
      modelReset();
      foreach (expQ[i]) if (expQ[i].due != cyc + 1) keep.push_back(expQ[i]);
      expQ = keep;
    end else if (v && ch < CHANNELS) begin
      modelPush(ch, data, avg);
      expQ.push_back('{cyc + 2, ch, avg});
    end
    @(posedge clk);
    #1;
  endtask

  // Every cycle must carry either exactly the scheduled result or nothing at all.
  always @(negedge clk) begin
    if (expQ.size() > 0 && expQ[0].due == cyc) begin
      checkOutput("outValid", 32'(out_valid), 1);
      checkOutput("outCh", 32'(out_ch), expQ[0].ch);
      checkOutput("outData", 32'(out_data), expQ[0].data);
      void'(expQ.pop_front());
    end else begin
      checkOutput("outValidIdle", 32'(out_valid), 0);
    end
    if (out_valid === 1'b1) observed.push_back('{int'(out_ch), int'(out_data)});
  end

  initial begin
    int last0;
    int last1;

    for (int i = 0; i < 10; i++) begin
`ifdef ANALOG_FILTER_PRIME_EN
      rampVecs[i] = '{0, 800, 800};
`else
      rampVecs[i] = '{0, 800, (i < 8) ? 100 * (i + 1) : 800};
`endif
    end
    for (int i = 0; i < 16; i++) begin
`ifdef ANALOG_FILTER_PRIME_EN
      stepVecs[i] = '{2, (i < 8) ? 1000 : 0, (i < 8) ? 1000 : 1000 - 125 * (i - 7)};
`else
      stepVecs[i] = '{2, (i < 8) ? 1000 : 0, (i < 8) ? 125 * (i + 1) : 1000 - 125 * (i - 7)};
`endif
    end

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0;
    #3;
    checkOutput("resetValid", 32'(out_valid), 0);
    checkOutput("resetCh", 32'(out_ch), 0);
    checkOutput("resetData", 32'(out_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    observed.delete();
    for (int i = 0; i < 10; i++) applyStimulus(1, rampVecs[i].ch, rampVecs[i].data, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("rampCount", observed.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < observed.size()) checkOutput("rampData", observed[i].data, rampVecs[i].expData);

    observed.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1, stepVecs[i].ch, stepVecs[i].data, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("stepCount", observed.size(), 16);
    for (int i = 0; i < 16; i++)
      if (i < observed.size()) checkOutput("stepData", observed[i].data, stepVecs[i].expData);

    observed.delete();
    for (int i = 0; i < 16; i++) applyStimulus(1, i % 2, (i % 2 == 0) ? 4095 : 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    last0 = -1; last1 = -1;
    foreach (observed[i]) begin
      if (observed[i].ch == 0) last0 = observed[i].data;
      if (observed[i].ch == 1) last1 = observed[i].data;
    end
    checkOutput("interleaveCount", observed.size(), 16);
    checkOutput("interleaveCh0", last0, 4095);
    checkOutput("interleaveCh1", last1, 0);

    for (int i = 0; i < 6; i++) applyStimulus(1, 0, $urandom_range(0, 4095), 0);
    applyStimulus(1, 0, 1234, 1);
    observed.delete();
    applyStimulus(1, 0, 800, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("clearCount", observed.size(), 1);
`ifdef ANALOG_FILTER_PRIME_EN
    if (observed.size() > 0) checkOutput("clearFirst", observed[0].data, 800);
`else
    if (observed.size() > 0) checkOutput("clearFirst", observed[0].data, 100);
`endif

    observed.delete();
    for (int c = 5; c < 8; c++) applyStimulus(1, c, 777, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("dropCount", observed.size(), 0);
    applyStimulus(1, 0, 800, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);

    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 2000, 0);
    in_valid = 1'b1; in_ch = 3'd1; in_data = 12'd2000;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetValid", 32'(out_valid), 0);
    checkOutput("midResetCh", 32'(out_ch), 0);
    checkOutput("midResetData", 32'(out_data), 0);
    expQ.delete();
    modelReset();
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    observed.delete();
    applyStimulus(1, 1, 800, 0);
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("warmRestartCount", observed.size(), 1);
`ifdef ANALOG_FILTER_PRIME_EN
    if (observed.size() > 0) checkOutput("warmRestart", observed[0].data, 800);
`else
    if (observed.size() > 0) checkOutput("warmRestart", observed[0].data, 100);
`endif

    for (int i = 0; i < 400; i++) begin
      int data;
      data = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : 4095)
                                         : int'($urandom_range(0, 4095));
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 7), data,
                    $urandom_range(0, 39) == 0);
    end
    repeat (3) applyStimulus(0, 0, 0, 0);
    checkOutput("pendingEmpty", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
